mod_dcache_nway: RTL and testbench

MOD_DCACHE_NWAY -- requirements
Module: mod_dcache_nway

---
 rtl/mod_dcache_nway.sv | 138 +++++++++++++
 tb/tb_mod_dcache_nway.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_dcache_nway.sv
// mod_dcache_nway: N-way set-associative write-back data cache with LRU replacement
module mod_dcache_nway #(
  parameter int WAYS = 4,
  parameter int LOGSETS_PER_WAY = 7,
  parameter int LOGWIDTH = 6,
  parameter int ADDRSIZE = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_reqcyc,
  output logic                         core_reqack,
  input  logic [ADDRSIZE-1:0]          core_req,
  input  logic [1:0]                   core_op,
  input  logic [63:0]                  core_reqdata,
  input  logic [7:0]                   core_wstrb,
  output logic                         core_respcyc,
  output logic [63:0]                  core_resp,
  output logic                         mem_reqcyc,
  input  logic                         mem_reqack,
  output logic [ADDRSIZE-1:0]          mem_req,
  output logic                         mem_we,
  output logic [8*(1<<LOGWIDTH)-1:0]   mem_reqdata,
  input  logic                         mem_respcyc,
  input  logic [8*(1<<LOGWIDTH)-1:0]   mem_resp
);
  localparam int LW = 8 * (1 << LOGWIDTH);
  localparam int SETS = 1 << LOGSETS_PER_WAY;
  localparam int TW = ADDRSIZE - LOGSETS_PER_WAY - LOGWIDTH;
  localparam int AW = $clog2(WAYS);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP} state_t;
  state_t state, state_n;
  logic valid [WAYS][SETS];
  logic dirty [WAYS][SETS];
  logic [AW-1:0] age [WAYS][SETS];
  logic [TW-1:0] tags [WAYS][SETS];
  logic [LW-1:0] lines [WAYS][SETS];
  logic [ADDRSIZE-1:0] r_addr;
  logic [1:0] r_op;
  logic [63:0] r_data;
  logic [7:0] r_strb;
  logic [AW-1:0] vw, hway, vict, way, old_age;
  logic [LOGSETS_PER_WAY-1:0] idx;
  logic [TW-1:0] tg;
  logic [LOGWIDTH-4:0] wsel;
  logic hit, vdirty, is_wr, is_fl, fill_done, hit_upd;
  logic [LW-1:0] src, merged;
  logic [63:0] rword;
  logic [2:0] unused_lo;
  assign idx = r_addr[LOGWIDTH +: LOGSETS_PER_WAY];
  assign tg = r_addr[ADDRSIZE-1 -: TW];
  assign wsel = r_addr[3 +: LOGWIDTH-3];
  assign unused_lo = r_addr[2:0];
  assign is_wr = r_op == 2'd1;
  assign is_fl = r_op == 2'd2;
  assign core_reqack = state == IDLE && !reset;
  assign core_respcyc = state == RESP;
  assign mem_reqcyc = state == WB_REQ || state == FILL_REQ;
  assign mem_we = state == WB_REQ;
  assign mem_req = mem_we ? {tags[vw][idx], idx, {LOGWIDTH{1'b0}}} : {r_addr[ADDRSIZE-1:LOGWIDTH], {LOGWIDTH{1'b0}}};
  assign mem_reqdata = lines[vw][idx];
  always_comb begin
    hit = 1'b0;
    hway = '0;
    vict = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (valid[i][idx] && tags[i][idx] == tg) begin
        hit = 1'b1;
        hway = AW'(i);
      end
      if (age[i][idx] == AW'(WAYS-1)) vict = AW'(i);
    end
    for (int i = WAYS-1; i >= 0; i--)
      if (!valid[i][idx]) vict = AW'(i);
  end
  assign way = state == LOOKUP ? (hit ? hway : vict) : vw;
  assign old_age = age[way][idx];
  assign vdirty = valid[way][idx] && dirty[way][idx];
  assign fill_done = state == FILL_WAIT && mem_respcyc;
  assign hit_upd = state == LOOKUP && hit && !is_fl;
  always_comb begin
    src = state == FILL_WAIT ? mem_resp : lines[way][idx];
    merged = src;
    for (int b = 0; b < 8; b++)
      if (is_wr && r_strb[b]) merged[{wsel, 3'(b), 3'b000} +: 8] = r_data[8*b +: 8];
    rword = src[{wsel, 6'b000000} +: 64];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (core_reqcyc) state_n = LOOKUP;
      LOOKUP:    state_n = is_fl ? (hit && vdirty ? WB_REQ : RESP) : hit ? RESP : vdirty ? WB_REQ : FILL_REQ;
      WB_REQ:    if (mem_reqack) state_n = WB_WAIT;
      WB_WAIT:   if (mem_respcyc) state_n = is_fl ? RESP : FILL_REQ;
      FILL_REQ:  if (mem_reqack) state_n = FILL_WAIT;
      FILL_WAIT: if (mem_respcyc) state_n = RESP;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      core_resp <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          valid[w][s] <= 1'b0;
          dirty[w][s] <= 1'b0;
          age[w][s] <= AW'(w);
        end
    end else begin
      state <= state_n;
      core_resp <= state_n == RESP && !is_wr && !is_fl ? rword : '0;
      if (hit_upd || fill_done)
        for (int i = 0; i < WAYS; i++)
          age[i][idx] <= AW'(i) == way ? '0 : age[i][idx] < old_age ? age[i][idx] + 1'b1 : age[i][idx];
      if (hit_upd && is_wr) dirty[way][idx] <= 1'b1;
      if (state == LOOKUP && hit && is_fl && !vdirty) valid[way][idx] <= 1'b0;
      if (state == WB_WAIT && mem_respcyc) begin
        dirty[way][idx] <= 1'b0;
        if (is_fl) valid[way][idx] <= 1'b0;
      end
      if (fill_done) begin
        valid[way][idx] <= 1'b1;
        dirty[way][idx] <= is_wr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (core_reqcyc && core_reqack) begin
      r_addr <= core_req;
      r_op <= core_op;
      r_data <= core_reqdata;
      r_strb <= core_wstrb;
    end
    if (state == LOOKUP) vw <= way;
    if ((state == LOOKUP && hit && is_wr) || fill_done) lines[way][idx] <= merged;
    if (fill_done) tags[way][idx] <= tg;
  end
endmodule

// File: tb/tb_mod_dcache_nway.sv
// tb_mod_dcache_nway: randomized check of the cache against a transparent-memory LRU model
module tb_mod_dcache_nway;
  localparam int WAYS = 4;
  logic clk = 1'b0;
  logic reset;
  logic core_reqcyc, core_reqack, core_respcyc, mem_reqcyc, mem_reqack, mem_we, mem_respcyc;
  logic [63:0] core_req, core_reqdata, core_resp, mem_req;
  logic [1:0] core_op;
  logic [7:0] core_wstrb;
  logic [511:0] mem_reqdata, mem_resp;
  int total = 0;
  int bad = 0;
  logic [511:0] dram [longint unsigned];
  logic [511:0] gold [longint unsigned];
  bit dm [longint unsigned];
  logic [63:0] lru_q [$];
  logic [63:0] r, a0;
  int lat, nm;
  logic w0;
  mod_dcache_nway dut (
    .clk(clk), .reset(reset),
    .core_reqcyc(core_reqcyc), .core_reqack(core_reqack), .core_req(core_req), .core_op(core_op),
    .core_reqdata(core_reqdata), .core_wstrb(core_wstrb), .core_respcyc(core_respcyc), .core_resp(core_resp),
    .mem_reqcyc(mem_reqcyc), .mem_reqack(mem_reqack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_reqdata(mem_reqdata), .mem_respcyc(mem_respcyc), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [511:0] g, input logic [511:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, g, e);
    end
  endtask
  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction
  task automatic preset(input logic [63:0] la, input logic [511:0] l);
    dram[la] = l;
    gold[la] = l;
  endtask
  task automatic do_req(input logic [63:0] a, input logic [1:0] op, input logic [63:0] d, input logic [7:0] s,
                        input int hold, input bit kill, output logic [63:0] rr, output int lt, output int nmo,
                        output logic wf, output logic [63:0] af);
    logic [63:0] la, v, er, sa;
    logic [511:0] ln, sd;
    logic ew [2];
    logic [63:0] ea [2];
    logic [511:0] ed [2];
    logic sw;
    int ne, pos, cnt, vpos, ph, dl;
    bit done, killed;
    la = {a[63:6], 6'b0};
    if (!dram.exists(la)) preset(la, rand_line());
    ne = 0; er = '0; pos = -1; cnt = 0; vpos = -1;
    foreach (lru_q[i]) begin
      if (lru_q[i] == la) pos = i;
      if (lru_q[i][12:6] == la[12:6]) begin
        cnt++;
        vpos = i;
      end
    end
    if (op == 2'd2) begin
      if (pos >= 0) begin
        if (dm.exists(la)) begin
          ew[0] = 1'b1; ea[0] = la; ed[0] = gold[la]; ne = 1;
          dm.delete(la);
        end
        lru_q.delete(pos);
      end
    end else begin
      if (pos >= 0) lru_q.delete(pos);
      else begin
        if (cnt == WAYS) begin
          v = lru_q[vpos];
          if (dm.exists(v)) begin
            ew[0] = 1'b1; ea[0] = v; ed[0] = gold[v]; ne = 1;
            dm.delete(v);
          end
          lru_q.delete(vpos);
        end
        ew[ne] = 1'b0; ea[ne] = la; ed[ne] = '0; ne++;
      end
      lru_q.push_front(la);
      ln = gold[la];
      if (op == 2'd1) begin
        for (int b = 0; b < 8; b++) if (s[b]) ln[a[5:3]*64 + b*8 +: 8] = d[b*8 +: 8];
        gold[la] = ln;
        dm[la] = 1'b1;
      end else er = ln[a[5:3]*64 +: 64];
    end
    @(negedge clk);
    chk("idle_reqack", core_reqack, 1'b1);
    chk("idle_respcyc", core_respcyc, 1'b0);
    core_reqcyc = 1'b1; core_req = a; core_op = op; core_reqdata = d; core_wstrb = s;
    @(posedge clk);
    #1;
    core_reqcyc = 1'b0; core_req = {$urandom, $urandom}; core_op = 2'($urandom);
    core_reqdata = {$urandom, $urandom}; core_wstrb = 8'($urandom);
    rr = '0; lt = -1; nmo = 0; wf = 1'b0; af = '0; ph = 0; dl = 0; done = 0; killed = 0;
    sw = 1'b0; sa = '0; sd = '0;
    for (int c = 1; c <= 150 && !done; c++) begin
      @(negedge clk);
      mem_reqack = 1'b0;
      mem_respcyc = 1'b0;
      if (core_respcyc) begin
        lt = c; rr = core_resp; done = 1;
      end else begin
        chk("busy_reqack", core_reqack, 1'b0);
        if (ph == 0) begin
          if (mem_reqcyc) begin
            if (nmo < ne) begin
              chk("mem_we", mem_we, ew[nmo]);
              chk("mem_req", mem_req, ea[nmo]);
              if (ew[nmo]) chk("wb_data", mem_reqdata, ed[nmo]);
            end else begin
              total++; bad++;
              $display("FAIL mem_extra got=%0h exp=none", mem_req);
            end
            if (nmo == 0) begin
              wf = mem_we; af = mem_req;
            end
            nmo++;
            sw = mem_we; sa = mem_req; sd = mem_reqdata;
            dl = hold > 0 ? hold : $urandom_range(0, 3);
            ph = 1;
          end else begin
            mem_respcyc = $urandom_range(0, 3) == 0;
            mem_reqack = $urandom_range(0, 3) == 0;
            mem_resp = rand_line();
          end
        end
        if (ph == 1) begin
          chk("hold_req", {mem_reqcyc, mem_we, mem_req}, {1'b1, sw, sa});
          chk("hold_data", mem_reqdata, sd);
          if (dl == 0) begin
            mem_reqack = 1'b1;
            ph = 2;
          end else dl--;
        end else if (ph == 2) begin
          chk("mem_drop", mem_reqcyc, 1'b0);
          if (kill && !sw) begin
            reset = 1'b1;
            #1 chk("rst_reqack", core_reqack, 1'b0);
            @(posedge clk);
            #1 reset = 1'b0;
            chk("rst_memreq", mem_reqcyc, 1'b0);
            chk("rst_respcyc", core_respcyc, 1'b0);
            repeat (5) begin
              @(negedge clk);
              chk("abort_resp", core_respcyc, 1'b0);
              chk("abort_mem", mem_reqcyc, 1'b0);
            end
            lru_q.delete();
            dm.delete();
            foreach (dram[k]) gold[k] = dram[k];
            done = 1; killed = 1;
          end else begin
            dl = $urandom_range(0, 3);
            ph = 3;
          end
        end else if (ph == 3) begin
          if (dl == 0) begin
            mem_respcyc = 1'b1;
            mem_resp = sw ? rand_line() : dram[sa];
            if (sw) dram[sa] = sd;
            ph = 0;
          end else dl--;
        end
      end
    end
    mem_reqack = 1'b0;
    mem_respcyc = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout got=no_resp exp=resp addr=%0h", a);
    end else if (!killed) begin
      chk("mem_count", nmo, ne);
      chk("resp", rr, er);
      if (ne == 0) chk("hit_lat", lt, 2);
    end
  endtask
  initial begin
    reset = 1'b1;
    core_reqcyc = 1'b0; core_req = '0; core_op = '0; core_reqdata = '0; core_wstrb = '0;
    mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", core_reqack, 1'b0);
    chk("rst_respcyc", core_respcyc, 1'b0);
    chk("rst_memreqcyc", mem_reqcyc, 1'b0);
    chk("rst_memwe", mem_we, 1'b0);
    chk("rst_resp", core_resp, 64'h0);
    reset = 1'b0;
    preset(64'h1000, {384'h0, 64'hDEADBEEF_CAFEF00D, 64'hAA});
    do_req(64'h1000, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("first_fill_addr", a0, 64'h1000);
    chk("first_fill_we", w0, 1'b0);
    chk("first_read", r, 64'hAA);
    do_req(64'h1000, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("rehit_lat", lat, 2);
    chk("rehit_nomem", nm, 0);
    chk("rehit_data", r, 64'hAA);
    do_req(64'h1008, 2'd1, 64'h11223344_55667788, 8'h0F, 0, 0, r, lat, nm, w0, a0);
    chk("write_resp", r, 64'h0);
    do_req(64'h1008, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("merged_word", r, 64'hDEADBEEF_55667788);
    do_req(64'h1000, 2'd2, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("flush_wb_count", nm, 1);
    chk("flush_wb_we", w0, 1'b1);
    chk("flush_wb_addr", a0, 64'h1000);
    do_req(64'h1008, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("post_flush_miss", nm, 1);
    chk("post_flush_data", r, 64'hDEADBEEF_55667788);
    for (int t = 1; t <= 4; t++) do_req((64'(t) << 13) | 64'h140, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    do_req(64'h2140, 2'd1, {$urandom, $urandom}, 8'hFF, 0, 0, r, lat, nm, w0, a0);
    for (int t = 2; t <= 4; t++) do_req((64'(t) << 13) | 64'h140, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    do_req(64'hA140, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("evict_count", nm, 2);
    chk("evict_we", w0, 1'b1);
    chk("evict_addr", a0, 64'h2140);
    do_req(64'h3_0000, 2'd0, '0, '0, 10, 0, r, lat, nm, w0, a0);
    chk("stall_fill", nm, 1);
    do_req(64'h7_0000, 2'd0, '0, '0, 0, 1, r, lat, nm, w0, a0);
    do_req(64'h7_0000, 2'd0, '0, '0, 0, 0, r, lat, nm, w0, a0);
    chk("post_reset_miss", nm, 1);
    for (int n = 0; n < 400; n++)
      do_req((64'($urandom_range(0, 5)) << 13) | (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63)),
             2'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom), 0, 0, r, lat, nm, w0, a0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
